// File: rtl/gpr_file_snapshot_if.sv
// Register-file bus: two async read ports, one write port, and the commit-aligned snapshot outputs.
// master = core side driving addresses/writes/commits, slave = the register file itself.
interface gpr_file_snapshot_if #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
);
  logic [ADDR_W-1:0]        rs1_addr;
  logic [XLEN-1:0]          rs1_data;
  logic [ADDR_W-1:0]        rs2_addr;
  logic [XLEN-1:0]          rs2_data;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [XLEN-1:0]          wr_data;
  logic                     commit_valid;
  logic                     snap_valid;
  logic [NUM_REGS*XLEN-1:0] gprs;
  logic [63:0]              commit_count;

  // Handshake: there is no ready/backpressure. commit_valid is a per-cycle qualifier
  // sampled at posedge; snap_valid pulses the cycle after each accepted commit, and gprs
  // and commit_count are stable whenever snap_valid is low.
  modport master (
    output rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, commit_valid,
    input  rs1_data, rs2_data, snap_valid, gprs, commit_count
  );

  modport slave (
    input  rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, commit_valid,
    output rs1_data, rs2_data, snap_valid, gprs, commit_count
  );
endinterface

// File: rtl/gpr_file_snapshot.sv
// General-purpose register file with write-through bypass, hardwired x0, and a snapshot
// of the full architectural state that only advances on instruction retirement.
module gpr_file_snapshot #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input logic                i_clk,
  input logic                i_reset,
  gpr_file_snapshot_if.slave bus
);

  localparam logic [ADDR_W:0] LP_NUM_REGS = (ADDR_W+1)'(NUM_REGS);

  // x0 has no storage; entries start at 1.
  logic [XLEN-1:0]          r_regs [1:NUM_REGS-1];
  logic [NUM_REGS*XLEN-1:0] r_gprs;
  logic                     r_snap_valid;
  logic [63:0]              r_commit_count;

  logic                     w_wr_hit;
  logic [XLEN-1:0]          w_next_regs [1:NUM_REGS-1];
  logic [NUM_REGS*XLEN-1:0] w_next_flat;
  logic [XLEN-1:0]          w_rs1_data;
  logic [XLEN-1:0]          w_rs2_data;

  always_comb begin
    w_wr_hit = bus.wr_en && (bus.wr_addr != '0) && ({1'b0, bus.wr_addr} < LP_NUM_REGS);
  end

  // Post-write register state: what the array holds after this edge, used for both
  // the array update and the snapshot so the two can never disagree.
  always_comb begin
    for (int i = 1; i < NUM_REGS; i++) begin
      w_next_regs[i] = (w_wr_hit && (bus.wr_addr == ADDR_W'(i))) ? bus.wr_data : r_regs[i];
    end
  end

  always_comb begin
    w_next_flat = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      w_next_flat[i*XLEN +: XLEN] = w_next_regs[i];
    end
  end

  // Addresses 0 and >= NUM_REGS match no entry and fall through to zero.
  always_comb begin
    w_rs1_data = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (bus.rs1_addr == ADDR_W'(i)) begin
        w_rs1_data = w_next_regs[i];
      end
    end
  end

  always_comb begin
    w_rs2_data = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (bus.rs2_addr == ADDR_W'(i)) begin
        w_rs2_data = w_next_regs[i];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_gprs         <= '0;
      r_snap_valid   <= 1'b0;
      r_commit_count <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        r_regs[i] <= w_next_regs[i];
      end
      r_snap_valid <= bus.commit_valid;
      if (bus.commit_valid) begin
        r_gprs         <= w_next_flat;
        r_commit_count <= r_commit_count + 64'd1;
      end
    end
  end

  assign bus.rs1_data     = w_rs1_data;
  assign bus.rs2_data     = w_rs2_data;
  assign bus.snap_valid   = r_snap_valid;
  assign bus.gprs         = r_gprs;
  assign bus.commit_count = r_commit_count;

endmodule

// File: tb/tb_gpr_file_snapshot.sv
// Bench for gpr_file_snapshot: a 32-register and a 16-register instance driven in lockstep,
// compared against an array-based architectural model plus directed scenario checks.
module tb_gpr_file_snapshot;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gpr_file_snapshot_if #(.XLEN(32), .NUM_REGS(32), .ADDR_W(5)) bus32 ();
  gpr_file_snapshot_if #(.XLEN(32), .NUM_REGS(16), .ADDR_W(5)) bus16 ();

  gpr_file_snapshot #(.XLEN(32), .NUM_REGS(32), .ADDR_W(5)) u_dut32 (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus32)
  );

  gpr_file_snapshot #(.XLEN(32), .NUM_REGS(16), .ADDR_W(5)) u_dut16 (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus16)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural model: index 0 = 32-reg instance, 1 = 16-reg instance.
  int          nr [2] = '{32, 16};
  logic [31:0] m_regs [2][32];
  logic [31:0] m_gprs [2][32];
  logic [63:0] m_count [2];
  logic        m_snap [2];
  logic        chk_en = 1'b0;

  logic        d_rst, d_we, d_cv;
  logic [4:0]  d_wa, d_a1, d_a2;
  logic [31:0] d_wd;

  task automatic drive(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2, input logic cv);
    d_rst = r; d_we = we; d_wa = wa; d_wd = wd; d_a1 = a1; d_a2 = a2; d_cv = cv;
    rst = r;
    bus32.wr_en = we; bus32.wr_addr = wa; bus32.wr_data = wd;
    bus32.rs1_addr = a1; bus32.rs2_addr = a2; bus32.commit_valid = cv;
    bus16.wr_en = we; bus16.wr_addr = wa; bus16.wr_data = wd;
    bus16.rs1_addr = a1; bus16.rs2_addr = a2; bus16.commit_valid = cv;
  endtask

  function automatic logic [31:0] exp_read(input int d, input logic [4:0] a);
    if (a == 5'd0 || int'(a) >= nr[d]) return 32'h0;
    if (d_we && d_wa == a) return d_wd;
    return m_regs[d][a];
  endfunction

  task automatic model_update();
    for (int d = 0; d < 2; d++) begin
      if (d_rst) begin
        for (int i = 0; i < 32; i++) begin
          m_regs[d][i] = 32'h0;
          m_gprs[d][i] = 32'h0;
        end
        m_count[d] = 64'h0;
        m_snap[d]  = 1'b0;
      end else begin
        if (d_we && d_wa != 5'd0 && int'(d_wa) < nr[d]) m_regs[d][d_wa] = d_wd;
        m_snap[d] = d_cv;
        if (d_cv) begin
          for (int i = 0; i < nr[d]; i++) m_gprs[d][i] = m_regs[d][i];
          m_count[d] = m_count[d] + 64'd1;
        end
      end
    end
    if (d_rst) chk_en = 1'b1;
  endtask

  task automatic check_reads();
    check("rs1_32", {32'h0, bus32.rs1_data}, {32'h0, exp_read(0, d_a1)});
    check("rs2_32", {32'h0, bus32.rs2_data}, {32'h0, exp_read(0, d_a2)});
    check("rs1_16", {32'h0, bus16.rs1_data}, {32'h0, exp_read(1, d_a1)});
    check("rs2_16", {32'h0, bus16.rs2_data}, {32'h0, exp_read(1, d_a2)});
  endtask

  task automatic check_state();
    check("snap_32", {63'h0, bus32.snap_valid}, {63'h0, m_snap[0]});
    check("snap_16", {63'h0, bus16.snap_valid}, {63'h0, m_snap[1]});
    check("count_32", bus32.commit_count, m_count[0]);
    check("count_16", bus16.commit_count, m_count[1]);
    for (int i = 0; i < 32; i++) check("gprs_32", {32'h0, bus32.gprs[i*32 +: 32]}, {32'h0, m_gprs[0][i]});
    for (int i = 0; i < 16; i++) check("gprs_16", {32'h0, bus16.gprs[i*32 +: 32]}, {32'h0, m_gprs[1][i]});
  endtask

  // Inputs are driven just after negedge; reads checked before posedge, state after it.
  task automatic cycle();
    #1;
    if (chk_en) check_reads();
    @(posedge clk);
    model_update();
    #1;
    if (chk_en) check_state();
    @(negedge clk);
  endtask

  initial begin
    // Reset held two cycles
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
    cycle();
    cycle();

    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b0);
    #1;
    check("t1_rs1_x5", {32'h0, bus32.rs1_data}, 64'h0);
    check("t1_count", bus32.commit_count, 64'h0);
    check("t1_snap", {63'h0, bus32.snap_valid}, 64'h0);
    check("t1_gprs_x5", {32'h0, bus32.gprs[5*32 +: 32]}, 64'h0);
    cycle();

    // Write + same-cycle bypass
    drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b0);
    #1;
    check("t2_bypass", {32'h0, bus32.rs1_data}, 64'hDEADBEEF);
    cycle();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd5, 1'b0);
    #1;
    check("t2_rs2_next", {32'h0, bus32.rs2_data}, 64'hDEADBEEF);
    cycle();

    // x0 and out-of-range writes
    drive(1'b0, 1'b1, 5'd0, 32'h1234, 5'd0, 5'd20, 1'b0);
    cycle();
    drive(1'b0, 1'b1, 5'd20, 32'h5555, 5'd20, 5'd0, 1'b1);
    #1;
    check("t3_x20_16", {32'h0, bus16.rs1_data}, 64'h0);
    check("t3_x20_32", {32'h0, bus32.rs1_data}, 64'h5555);
    cycle();
    check("t3_gprs_x0", {32'h0, bus32.gprs[31:0]}, 64'h0);
    check("t3_gprs32_x20", {32'h0, bus32.gprs[20*32 +: 32]}, 64'h5555);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd20, 1'b0);
    #1;
    check("t3_x20_16_rd", {32'h0, bus16.rs2_data}, 64'h0);
    cycle();

    // Commit alignment
    drive(1'b0, 1'b1, 5'd3, 32'd7, 5'd3, 5'd4, 1'b0);
    cycle();
    check("t4_snap_lo", {63'h0, bus32.snap_valid}, 64'h0);
    drive(1'b0, 1'b1, 5'd4, 32'd9, 5'd3, 5'd4, 1'b1);
    cycle();
    check("t4_snap", {63'h0, bus32.snap_valid}, 64'h1);
    check("t4_x3", {32'h0, bus32.gprs[3*32 +: 32]}, 64'd7);
    check("t4_x4", {32'h0, bus32.gprs[4*32 +: 32]}, 64'd9);
    check("t4_count", bus32.commit_count, 64'd2);
    drive(1'b0, 1'b1, 5'd3, 32'd8, 5'd3, 5'd0, 1'b0);
    cycle();
    check("t4_x3_hold", {32'h0, bus32.gprs[3*32 +: 32]}, 64'd7);
    check("t4_snap_drop", {63'h0, bus32.snap_valid}, 64'h0);

    // Back-to-back commits
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 1'b1, 5'd1, 32'(k), 5'd1, 5'd3, 1'b1);
      cycle();
      check("t5_snap", {63'h0, bus16.snap_valid}, 64'h1);
      check("t5_x1", {32'h0, bus16.gprs[63:32]}, 64'(k));
    end
    check("t5_count", bus32.commit_count, 64'd6);

    // Reset mid-operation
    drive(1'b1, 1'b1, 5'd2, 32'd5, 5'd2, 5'd0, 1'b1);
    cycle();
    check("t6_snap", {63'h0, bus32.snap_valid}, 64'h0);
    check("t6_count", bus32.commit_count, 64'h0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd2, 5'd2, 1'b0);
    #1;
    check("t6_x2", {32'h0, bus32.rs1_data}, 64'h0);
    cycle();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic       r, we, cv;
      logic [4:0] wa, a1, a2;
      r  = ($urandom_range(0, 99) < 2);
      we = 1'($urandom_range(0, 1));
      cv = 1'($urandom_range(0, 1));
      wa = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      drive(r, we, wa, $urandom, a1, a2, cv);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
